// File: rtl/eth_mac_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC TX FIFO stream.
// Holds a grant for a whole frame; aborts stalled frames with a bad beat.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_axis_*              PORTS packed requester streams (tready per port)
//   m_axis_*              merged stream to TX FIFO, tid = source port
//   cfg_port_enable       ports eligible for a new grant
//   status_grant          one-hot current grant, 0 when idle
//   status_timeout        pulse on the cycle after an abort beat is taken
//   status_timeout_port   port of the most recent abort

module eth_mac_tx_frame_arbiter #(
  parameter int PORTS         = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 1,
  parameter int ID_WIDTH      = $clog2(PORTS),
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic [PORTS-1:0]                 s_axis_tvalid,
  output logic [PORTS-1:0]                 s_axis_tready,
  input  logic [PORTS-1:0]                 s_axis_tlast,
  input  logic [PORTS*USER_WIDTH-1:0]      s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic [PORTS-1:0]                 cfg_port_enable,
  output logic [PORTS-1:0]                 status_grant,
  output logic                             status_timeout,
  output logic [ID_WIDTH-1:0]              status_timeout_port
);

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    ABORT,
    DRAIN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STALL_LAST =
    CNT_WIDTH'(STALL_TIMEOUT == 0 ? 0 : STALL_TIMEOUT - 1);

  state_t                state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  logic [PORTS-1:0]      req;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   cand;
  int                    idx;

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_valid;
  logic                  sel_last;

  assign req = s_axis_tvalid & cfg_port_enable;

  // Walk from farthest to nearest so the port closest after
  // rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    idx  = 0;
    for (int i = PORTS; i >= 1; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      cand = ID_WIDTH'(idx);
      if (req[cand]) pick = cand;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    m_axis_tid    = grant;
    s_axis_tready = '0;
    status_grant  = '0;
    if (state != IDLE) status_grant[grant] = 1'b1;
    unique case (state)
      PASS: begin
        m_axis_tdata  = sel_data;
        m_axis_tkeep  = sel_keep;
        m_axis_tvalid = sel_valid;
        m_axis_tlast  = sel_last;
        m_axis_tuser  = sel_user;
        s_axis_tready[grant] = m_axis_tready;
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tkeep  = KEEP_WIDTH'(1);
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = USER_WIDTH'(1);
      end
      DRAIN: s_axis_tready[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      grant               <= '0;
      rr_ptr              <= ID_WIDTH'(PORTS - 1);
      stall_cnt           <= '0;
      status_timeout      <= 1'b0;
      status_timeout_port <= '0;
    end else begin
      status_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant     <= pick;
            rr_ptr    <= pick;
            stall_cnt <= '0;
            state     <= PASS;
          end
        end
        PASS: begin
          // A beat present on the threshold cycle beats the abort.
          if (sel_valid) begin
            stall_cnt <= '0;
            if (m_axis_tready && sel_last) state <= IDLE;
          end else if (STALL_TIMEOUT != 0 &&
                       stall_cnt == STALL_LAST) begin
            state <= ABORT;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
          end
        end
        ABORT: begin
          if (m_axis_tready) begin
            status_timeout      <= 1'b1;
            status_timeout_port <= grant;
            state               <= DRAIN;
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_frame_arbiter.sv
// Directed bench for eth_mac_tx_frame_arbiter.
// Four scripted sources, a beat log on the master side.

module tb_eth_mac_tx_frame_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [3:0]   s_axis_tvalid;
  logic [3:0]   s_axis_tready;
  logic [3:0]   s_axis_tlast;
  logic [3:0]   s_axis_tuser;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [1:0]   m_axis_tid;
  logic [0:0]   m_axis_tuser;
  logic [3:0]   cfg_port_enable;
  logic [3:0]   status_grant;
  logic         status_timeout;
  logic [1:0]   status_timeout_port;

  eth_mac_tx_frame_arbiter #(
    .PORTS(4),
    .DATA_WIDTH(64),
    .STALL_TIMEOUT(8),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid),
    .m_axis_tuser(m_axis_tuser),
    .cfg_port_enable(cfg_port_enable),
    .status_grant(status_grant),
    .status_timeout(status_timeout),
    .status_timeout_port(status_timeout_port)
  );

  always #5 clk = ~clk;

  int src_len[4];
  int src_idx[4];
  int gap_at[4];
  int gap_left[4];
  int src_acc[4];

  logic [63:0] lg_data[$];
  logic [7:0]  lg_keep[$];
  logic [1:0]  lg_tid[$];
  logic        lg_last[$];
  logic        lg_user[$];
  logic [3:0]  lg_gnt[$];
  int          lg_cyc[$];

  int cyc;
  int to_cnt;
  logic [1:0] to_port;
  int n_chk;
  int n_fail;

  function automatic logic [63:0] pat(int p, int i);
    return 64'hD000_0000_0000_0000 | (64'(p) << 8) | 64'(i);
  endfunction

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      s_axis_tdata[p*64 +: 64] = pat(p, src_idx[p]);
      s_axis_tkeep[p*8 +: 8]   = 8'hFF;
      s_axis_tuser[p]  = 1'b0;
      s_axis_tlast[p]  = (src_idx[p] == src_len[p] - 1);
      s_axis_tvalid[p] = (src_idx[p] < src_len[p]) &&
        !(src_idx[p] == gap_at[p] && gap_left[p] > 0);
    end
  endtask

  task automatic load(int p, int len);
    src_len[p]  = len;
    src_idx[p]  = 0;
    gap_at[p]   = -1;
    gap_left[p] = 0;
    src_acc[p]  = 0;
    drive();
  endtask

  task automatic clear_log();
    lg_data.delete(); lg_keep.delete(); lg_tid.delete();
    lg_last.delete(); lg_user.delete(); lg_gnt.delete();
    lg_cyc.delete();
  endtask

  // Sample at negedge, advance sources just after posedge.
  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk);
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      lg_data.push_back(m_axis_tdata);
      lg_keep.push_back(m_axis_tkeep);
      lg_tid.push_back(m_axis_tid);
      lg_last.push_back(m_axis_tlast);
      lg_user.push_back(m_axis_tuser[0]);
      lg_gnt.push_back(status_grant);
      lg_cyc.push_back(cyc);
    end
    if (status_timeout) begin
      to_cnt++;
      to_port = status_timeout_port;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++) begin
      if (acc[p]) begin
        src_idx[p]++;
        src_acc[p]++;
      end else if (src_idx[p] < src_len[p] &&
                   src_idx[p] == gap_at[p] && gap_left[p] > 0) begin
        gap_left[p]--;
      end
    end
    drive();
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) load(p, 0);
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    cfg_port_enable = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (s_axis_tready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_s_tready got %b want 0000", s_axis_tready);
    end
    n_chk++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_m_tvalid got %b want 0", m_axis_tvalid);
    end
    n_chk++;
    if (status_grant !== 4'h0 || status_timeout !== 1'b0 ||
        status_timeout_port !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_status got %b/%b/%0d want 0/0/0",
               status_grant, status_timeout, status_timeout_port);
    end
    rst_n = 1'b1;
    repeat (3) cycle();
    n_chk++;
    if (status_grant !== 4'h0 || m_axis_tvalid !== 1'b0 ||
        s_axis_tready !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_quiet got gnt=%b mv=%b sr=%b want 0",
               status_grant, m_axis_tvalid, s_axis_tready);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    clear_log();
    load(0, 3); load(1, 3); load(2, 3);
    c0 = cyc;
    repeat (14) cycle();
    n_chk++;
    if (lg_tid.size() !== 9) begin
      n_fail++;
      $display("FAIL rr_count got %0d want 9", lg_tid.size());
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (lg_tid[i] !== 2'(i/3) || lg_data[i] !== pat(i/3, i%3) ||
          lg_last[i] !== (i%3 == 2) || lg_gnt[i] !== 4'(1 << (i/3)) ||
          lg_keep[i] !== 8'hFF || lg_user[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_beat%0d got tid=%0d d=%h l=%b g=%b want tid=%0d d=%h l=%b",
                 i, lg_tid[i], lg_data[i], lg_last[i], lg_gnt[i],
                 i/3, pat(i/3, i%3), (i%3 == 2));
      end
    end
    n_chk++;
    if (lg_cyc[0] !== c0 + 1) begin
      n_fail++;
      $display("FAIL rr_first_lat got %0d want %0d", lg_cyc[0], c0 + 1);
    end
    n_chk++;
    if (lg_cyc[3] - lg_cyc[2] !== 2 || lg_cyc[6] - lg_cyc[5] !== 2 ||
        lg_cyc[1] - lg_cyc[0] !== 1) begin
      n_fail++;
      $display("FAIL rr_gap got %0d/%0d/%0d want 2/2/1",
               lg_cyc[3] - lg_cyc[2], lg_cyc[6] - lg_cyc[5],
               lg_cyc[1] - lg_cyc[0]);
    end
  endtask

  task automatic test_rr_wrap();
    clear_log();
    load(0, 2); load(3, 2);
    repeat (10) cycle();
    n_chk++;
    if (lg_tid.size() !== 4) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want 4", lg_tid.size());
    end
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (i < 2) ? 3 : 0;
      n_chk++;
      if (lg_tid[i] !== 2'(p) || lg_data[i] !== pat(p, i%2)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d got tid=%0d d=%h want tid=%0d d=%h",
                 i, lg_tid[i], lg_data[i], p, pat(p, i%2));
      end
    end
  endtask

  task automatic test_timeout();
    logic [63:0] ed[5];
    logic [7:0]  ek[5];
    logic [1:0]  et[5];
    logic        el[5];
    logic        eu[5];
    clear_log();
    to_cnt = 0;
    load(1, 5);
    gap_at[1] = 2;
    gap_left[1] = 20;
    load(2, 2);
    ed = '{pat(1,0), pat(1,1), 64'd0, pat(2,0), pat(2,1)};
    ek = '{8'hFF, 8'hFF, 8'h01, 8'hFF, 8'hFF};
    et = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    repeat (45) cycle();
    n_chk++;
    if (lg_tid.size() !== 5) begin
      n_fail++;
      $display("FAIL to_count got %0d want 5", lg_tid.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (lg_data[i] !== ed[i] || lg_keep[i] !== ek[i] ||
          lg_tid[i] !== et[i] || lg_last[i] !== el[i] ||
          lg_user[i] !== eu[i]) begin
        n_fail++;
        $display("FAIL to_beat%0d got d=%h k=%h t=%0d l=%b u=%b want d=%h k=%h t=%0d l=%b u=%b",
                 i, lg_data[i], lg_keep[i], lg_tid[i], lg_last[i],
                 lg_user[i], ed[i], ek[i], et[i], el[i], eu[i]);
      end
    end
    n_chk++;
    if (lg_cyc[2] - lg_cyc[1] !== 9) begin
      n_fail++;
      $display("FAIL to_delay got %0d want 9", lg_cyc[2] - lg_cyc[1]);
    end
    n_chk++;
    if (to_cnt !== 1 || to_port !== 2'd1) begin
      n_fail++;
      $display("FAIL to_pulse got cnt=%0d port=%0d want 1/1", to_cnt, to_port);
    end
    n_chk++;
    if (status_timeout_port !== 2'd1) begin
      n_fail++;
      $display("FAIL to_port_hold got %0d want 1", status_timeout_port);
    end
    n_chk++;
    if (src_acc[1] !== 5 || src_acc[2] !== 2) begin
      n_fail++;
      $display("FAIL to_drain got p1=%0d p2=%0d want 5/2", src_acc[1], src_acc[2]);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    to_cnt = 0;
    load(3, 4);
    for (int k = 0; k < 20 && lg_tid.size() < 2; k++) cycle();
    n_chk++;
    if (lg_tid.size() !== 2) begin
      n_fail++;
      $display("FAIL bp_start got %0d want 2", lg_tid.size());
    end
    m_axis_tready = 1'b0;
    repeat (50) cycle();
    n_chk++;
    if (lg_tid.size() !== 2 || to_cnt !== 0 || status_grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_hold got n=%0d to=%0d g=%b want 2/0/1000",
               lg_tid.size(), to_cnt, status_grant);
    end
    m_axis_tready = 1'b1;
    repeat (10) cycle();
    n_chk++;
    if (lg_tid.size() !== 4 || to_cnt !== 0) begin
      n_fail++;
      $display("FAIL bp_count got n=%0d to=%0d want 4/0", lg_tid.size(), to_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (lg_tid[i] !== 2'd3 || lg_data[i] !== pat(3, i) ||
          lg_last[i] !== (i == 3) || lg_user[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_beat%0d got t=%0d d=%h l=%b want t=3 d=%h l=%b",
                 i, lg_tid[i], lg_data[i], lg_last[i], pat(3, i), (i == 3));
      end
    end
  endtask

  task automatic test_port_enable();
    bit cleared;
    logic [1:0] et[9];
    cleared = 1'b0;
    clear_log();
    cfg_port_enable = 4'b1101;
    et = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int p = 0; p < 4; p++) load(p, 3);
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (!cleared && lg_tid.size() > 0) begin
        cfg_port_enable[0] = 1'b0;
        cleared = 1'b1;
      end
    end
    n_chk++;
    if (lg_tid.size() !== 9) begin
      n_fail++;
      $display("FAIL en_count got %0d want 9", lg_tid.size());
    end
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (lg_tid[i] !== et[i] || lg_data[i] !== pat(int'(et[i]), i%3)) begin
        n_fail++;
        $display("FAIL en_beat%0d got t=%0d d=%h want t=%0d d=%h",
                 i, lg_tid[i], lg_data[i], et[i], pat(int'(et[i]), i%3));
      end
    end
    n_chk++;
    if (src_acc[1] !== 0 || status_grant !== 4'h0) begin
      n_fail++;
      $display("FAIL en_block got acc1=%0d g=%b want 0/0000",
               src_acc[1], status_grant);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    cfg_port_enable = 4'hF;
    load(0, 0); load(1, 0); load(3, 0);
    load(2, 6);
    for (int k = 0; k < 10 && lg_tid.size() < 2; k++) cycle();
    n_chk++;
    if (m_axis_tvalid !== 1'b1 || status_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mr_pre got mv=%b g=%b want 1/0100",
               m_axis_tvalid, status_grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (s_axis_tready !== 4'h0 || m_axis_tvalid !== 1'b0 ||
        status_grant !== 4'h0) begin
      n_fail++;
      $display("FAIL mr_async got sr=%b mv=%b g=%b want 0/0/0",
               s_axis_tready, m_axis_tvalid, status_grant);
    end
    n_chk++;
    if (status_timeout_port !== 2'd0) begin
      n_fail++;
      $display("FAIL mr_status got %0d want 0", status_timeout_port);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    load(2, 0); load(0, 2); load(3, 2);
    repeat (10) cycle();
    n_chk++;
    if (lg_tid.size() !== 4) begin
      n_fail++;
      $display("FAIL mr_count got %0d want 4", lg_tid.size());
    end
    for (int i = 0; i < 4; i++) begin
      int p;
      p = (i < 2) ? 0 : 3;
      n_chk++;
      if (lg_tid[i] !== 2'(p) || lg_data[i] !== pat(p, i%2)) begin
        n_fail++;
        $display("FAIL mr_beat%0d got t=%0d d=%h want t=%0d d=%h",
                 i, lg_tid[i], lg_data[i], p, pat(p, i%2));
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    to_cnt = 0;
    to_port = 2'd0;
    test_reset();
    test_round_robin();
    test_rr_wrap();
    test_timeout();
    test_backpressure();
    test_port_enable();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
